// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Serial transmitter that drains the TX byte FIFO and sends each
//            byte on the UART pin as a frame of one start bit, DATA_BITS data
//            bits sent LSB first, an optional parity bit and STOP_BITS stop
//            bits. Every bit lasts CLKS_PER_BIT clock cycles.
// Optional : define UART_TX_PARITY_EN to add one even-parity bit between the
//            data bits and the stop bit(s).
// Ports    : clk             - single clock
//            reset_n         - synchronous, active-low reset
//            tx_en           - lets new frames start; a frame in progress
//                              always completes
//            fifo_empty      - FIFO empty flag
//            fifo_data       - FIFO head word
//            fifo_data_valid - FIFO accepted the pop in this cycle
//            fifo_pop        - pop request to the FIFO (combinational)
//            tx              - serial line, idle high (registered)
//            busy            - a frame is in progress
//            frame_done      - pulse in the last cycle of the last stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_data_valid,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_BITS - 1);
  // Stop-bit index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic              C_STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q,  baud_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic                 stop_q,  stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q,   par_d;
`endif

  logic baud_end;
  logic last_stop;
  logic capture;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // The baud counter free-runs inside a frame and wraps on bit boundaries.
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_START;
          shift_d = fifo_data;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == C_BIT_LAST) begin
            bit_d  = '0;
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (stop_q == C_STOP_LAST) begin
            stop_d = 1'b0;
            // A pop accepted in the final stop cycle starts the next frame
            // with no idle gap on the line.
            if (capture) begin
              state_d = S_START;
              shift_d = fifo_data;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_TX_PARITY_EN
    if (capture) begin
      par_d = ^fifo_data;
    end
`endif

    // The line is registered, so it is driven from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    baud_end  = (baud_q == C_BAUD_LAST);
    last_stop = (state_q == S_STOP) && baud_end && (stop_q == C_STOP_LAST);
    // Gated by reset so no pop is issued while reset is held.
    fifo_pop   = reset_n && tx_en && !fifo_empty &&
                 ((state_q == S_IDLE) || last_stop);
    capture    = fifo_pop && fifo_data_valid;
    frame_done = last_stop;
    busy       = (state_q != S_IDLE);
  end

  assign tx = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx with CLKS_PER_BIT=4. A small
//            FIFO model feeds the transmitter; every byte written to it is
//            also queued as an expected frame, and a line monitor decodes
//            tx cycle by cycle against the head of that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL    = (1 + 8 + P + 1) * CPB;
  localparam int LIMIT = 4 * FL + 20;
  localparam int NV    = 7;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_data_valid;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       frame_done;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tx_en          (tx_en),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .fifo_pop       (fifo_pop),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model
  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty      = (wr_ptr == rd_ptr);
  assign fifo_data       = mem[rd_ptr[4:0]];
  assign fifo_data_valid = fifo_pop && !fifo_empty;

  always @(posedge clk) begin
    if (fifo_pop === 1'b1 && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  // Event counters sampled mid-cycle
  int pops = 0;
  int busy_cyc = 0;
  int b2b = 0;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && fifo_pop === 1'b1 && !fifo_empty) pops++;
    if (busy === 1'b1) busy_cyc++;
    if (fifo_pop === 1'b1 && frame_done === 1'b1) b2b++;
  end

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tv[NV];

  logic       mon_en = 1'b0;
  logic       in_frame = 1'b0;
  logic       last_pop = 1'b0;
  logic       ferr;
  logic [7:0] got;
  vec_t       cur;
  int         mon_k = 0;
  int         frames = 0;
  int         idle_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic p);
    vec_t v;
    v.data = d;
    v.par  = p;
    return v;
  endfunction

  task automatic push(input vec_t v);
    mem[wr_ptr[4:0]] = v.data;
    wr_ptr++;
    sb.push_back(v);
  endtask

  // Decodes the line each cycle; the expected byte is popped at the start bit.
  task automatic monitor();
    int   b;
    logic e;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1 || !mon_en) begin
        in_frame = 1'b0;
        last_pop = 1'b0;
      end else begin
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1'b1;
            mon_k    = 0;
            ferr     = !last_pop;  // start bit must follow the pop cycle
            got      = '0;
            if (sb.size() == 0) begin
              check("sb_underflow", 32'd0, 32'd1);
              cur = mk(8'h00, 1'b0);
            end else begin
              cur = sb.pop_front();
            end
          end else if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            idle_err++;
          end
        end
        if (in_frame) begin
          b = mon_k / CPB;
          if (b == 0)                e = 1'b0;
          else if (b <= 8)           e = cur.data[b-1];
          else if (P == 1 && b == 9) e = cur.par;
          else                       e = 1'b1;
          if (b >= 1 && b <= 8 && (mon_k % CPB) == CPB / 2) got[b-1] = tx;
          if (tx !== e || busy !== 1'b1 || frame_done !== (mon_k == FL - 1)) ferr = 1'b1;
          if (mon_k == FL - 1) begin
            checks++;
            if (ferr) begin
              errors++;
              $display("FAIL frame: got data %h expected %h (line, busy, frame_done or latency wrong)",
                       got, cur.data);
            end
            frames++;
            in_frame = 1'b0;
          end else begin
            mon_k++;
          end
        end
        last_pop = (fifo_pop === 1'b1) && !fifo_empty;
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_wait", 32'(frames), 32'(target));
  endtask

  task automatic wait_k(input int kk);
    int n = 0;
    while (!(in_frame && mon_k == kk) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_bit", 32'(mon_k), 32'(kk));
  endtask

  int p0, b0, f0, k0;

  initial begin
    reset_n = 1'b0;
    tx_en   = 1'b1;
    tv[0] = mk(8'hA5, 1'b0);
    tv[1] = mk(8'h3C, 1'b0);
    tv[2] = mk(8'h81, 1'b0);
    tv[3] = mk(8'h01, 1'b1);
    tv[4] = mk(8'h80, 1'b1);
    tv[5] = mk(8'h07, 1'b1);
    tv[6] = mk(8'h5A, 1'b0);
    fork
      monitor();
    join_none

    // Reset held with a non-empty FIFO
    push(tv[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({tx, fifo_pop, busy, frame_done}), 32'h8);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single frames from the vector table
    for (int i = 0; i < NV; i++) begin
      if (i > 0) push(tv[i]);
      p0 = pops;
      b0 = busy_cyc;
      f0 = frames;
      wait_frames(f0 + 1);
      repeat (3) @(posedge clk);
      #1;
      check("single_pops", 32'(pops - p0), 32'd1);
      check("single_busy_cycles", 32'(busy_cyc - b0), 32'(FL));
    end

    // Back-to-back frames
    p0 = pops; b0 = busy_cyc; f0 = frames; k0 = b2b;
    push(mk(8'h00, 1'b0));
    push(mk(8'hFF, 1'b0));
    wait_frames(f0 + 2);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_pops", 32'(pops - p0), 32'd2);
    check("b2b_pop_in_last_stop", 32'(b2b - k0), 32'd1);
    check("b2b_busy_cycles", 32'(busy_cyc - b0), 32'(2 * FL));

    // tx_en dropped during the first data bit
    p0 = pops; f0 = frames;
    push(mk(8'h55, 1'b0));
    push(mk(8'hAA, 1'b0));
    wait_k(6);
    tx_en = 1'b0;
    wait_frames(f0 + 1);
    repeat (3 * FL) @(posedge clk);
    #1;
    check("en_drop_pops", 32'(pops - p0), 32'd1);
    check("en_drop_frames", 32'(frames), 32'(f0 + 1));
    check("en_drop_tx", 32'(tx), 32'd1);
    tx_en = 1'b1;
    wait_frames(f0 + 2);
    check("en_resume_pops", 32'(pops - p0), 32'd2);

    // Reset during data bit 3: popped byte is dropped, next byte follows
    f0 = frames;
    push(mk(8'h96, 1'b0));
    push(mk(8'h69, 1'b0));
    wait_k(17);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tx_busy", 32'({tx, busy}), 32'h2);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_frames(f0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_fifo_empty", 32'(fifo_empty), 32'd1);

    check("idle_line", 32'(idle_err), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
